// File: rtl/mem_stage_mw_pipe_if.sv
// Handshake and data bundle between execute, the memory stage and writeback.
// The slave modport is the stage side; the master modport is the driver side.
interface mem_stage_mw_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] op2_in;
  logic [31:0]       instr_in;
  logic [CTRL_W-1:0] control_in;
  logic [1:0]        size_in;
  logic              sign_in;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] ld_result_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [31:0]       instr_out;
  logic [CTRL_W-1:0] control_out;
  logic              misalign_out;
  logic              stall_out;

  modport master (
    output in_valid, pc_in, alu_result_in, op2_in, instr_in, control_in, size_in, sign_in,
    output flush, out_ready,
    input  in_ready, out_valid, pc_out, ld_result_out, alu_result_out, instr_out,
    input  control_out, misalign_out, stall_out
  );

  modport slave (
    input  in_valid, pc_in, alu_result_in, op2_in, instr_in, control_in, size_in, sign_in,
    input  flush, out_ready,
    output in_ready, out_valid, pc_out, ld_result_out, alu_result_out, instr_out,
    output control_out, misalign_out, stall_out
  );
endinterface

// File: rtl/mem_stage_mw_pipe.sv
// Memory-access stage with ME->WB pipeline register: sub-word little-endian loads/stores,
// fixed multi-cycle memory latency, misalignment detection, valid/ready back-pressure, flush.
module mem_stage_mw_pipe #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned CTRL_W      = 24,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned LD_BIT      = 13,
  parameter int unsigned ST_BIT      = 14
) (
  input logic               clk,
  input logic               rst,
  mem_stage_mw_pipe_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int unsigned MEM_BYTES = 1 << ADDR_W;
  localparam logic [2:0]  CNT_INIT  = (MEM_LATENCY == 0) ? 3'd0 : 3'(MEM_LATENCY - 1);
  localparam bit          HAS_LAT   = (MEM_LATENCY != 0);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] h_pc_q, h_alu_q, h_op2_q;
  logic [31:0]       h_instr_q;
  logic [CTRL_W-1:0] h_ctrl_q;
  logic [1:0]        h_size_q;
  logic              h_sign_q;

  logic [DATA_W-1:0] pc_q, ld_q, alu_q;
  logic [31:0]       instr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              mis_q;

  logic [7:0]        mem_q [MEM_BYTES];

  logic              in_ready, accept, in_wait, wait_done, direct, go_wait, complete, mem_we;
  logic [DATA_W-1:0] c_pc, c_alu, c_op2, ld_val;
  logic [31:0]       c_instr, ld_ext;
  logic [CTRL_W-1:0] c_ctrl;
  logic [1:0]        c_size;
  logic              c_sign, c_ld, c_st, c_mem, c_half, c_word, c_mis;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        rb0, rb1, rb2, rb3;

  // HOLD is only ever occupied with out_valid set, so accepting there is the back-to-back case.
  assign in_ready = (state_q != WAIT) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  assign in_wait  = (state_q == WAIT);

  // The op being completed comes straight from the inputs unless it is parked in WAIT.
  always_comb begin
    c_pc    = in_wait ? h_pc_q    : bus.pc_in;
    c_alu   = in_wait ? h_alu_q   : bus.alu_result_in;
    c_op2   = in_wait ? h_op2_q   : bus.op2_in;
    c_instr = in_wait ? h_instr_q : bus.instr_in;
    c_ctrl  = in_wait ? h_ctrl_q  : bus.control_in;
    c_size  = in_wait ? h_size_q  : bus.size_in;
    c_sign  = in_wait ? h_sign_q  : bus.sign_in;
  end

  assign c_ld   = c_ctrl[LD_BIT];
  assign c_st   = c_ctrl[ST_BIT];
  assign c_mem  = c_ld || c_st;
  assign c_word = c_size[1];
  assign c_half = (c_size == 2'b01);
  assign a0     = c_alu[ADDR_W-1:0];
  assign a1     = a0 + ADDR_W'(1);
  assign a2     = a0 + ADDR_W'(2);
  assign a3     = a0 + ADDR_W'(3);
  assign c_mis  = c_mem && ((c_half && a0[0]) || (c_word && (a0[1:0] != 2'b00)));

  assign rb0 = mem_q[a0];
  assign rb1 = mem_q[a1];
  assign rb2 = mem_q[a2];
  assign rb3 = mem_q[a3];

  always_comb begin
    case (c_size)
      2'b00:   ld_ext = {{24{c_sign & rb0[7]}}, rb0};
      2'b01:   ld_ext = {{16{c_sign & rb1[7]}}, rb1, rb0};
      default: ld_ext = {rb3, rb2, rb1, rb0};
    endcase
  end

  // Store wins when both LD and ST are set.
  assign ld_val = (c_ld && !c_st && !c_mis) ? DATA_W'(ld_ext) : '0;

  assign wait_done = in_wait && (cnt_q == 3'd0) && !bus.flush;
  assign direct    = accept && !(c_mem && !c_mis && HAS_LAT);
  assign go_wait   = accept && !direct;
  assign complete  = direct || wait_done;
  assign mem_we    = complete && c_st && !c_mis;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      state_d     = IDLE;
      cnt_d       = 3'd0;
      out_valid_d = 1'b0;
    end else if (complete) begin
      state_d     = HOLD;
      out_valid_d = 1'b1;
    end else if (go_wait) begin
      state_d     = WAIT;
      cnt_d       = CNT_INIT;
      out_valid_d = 1'b0;
    end else if (in_wait) begin
      cnt_d = cnt_q - 3'd1;
    end else if (out_valid_q && bus.out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
      h_pc_q      <= '0;
      h_alu_q     <= '0;
      h_op2_q     <= '0;
      h_instr_q   <= '0;
      h_ctrl_q    <= '0;
      h_size_q    <= '0;
      h_sign_q    <= 1'b0;
      pc_q        <= '0;
      ld_q        <= '0;
      alu_q       <= '0;
      instr_q     <= '0;
      ctrl_q      <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        h_pc_q    <= bus.pc_in;
        h_alu_q   <= bus.alu_result_in;
        h_op2_q   <= bus.op2_in;
        h_instr_q <= bus.instr_in;
        h_ctrl_q  <= bus.control_in;
        h_size_q  <= bus.size_in;
        h_sign_q  <= bus.sign_in;
      end
      if (complete) begin
        pc_q    <= c_pc;
        ld_q    <= ld_val;
        alu_q   <= c_alu;
        instr_q <= c_instr;
        ctrl_q  <= c_ctrl;
        mis_q   <= c_mis;
      end
    end
  end

  // Data memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[a0] <= c_op2[7:0];
      if (c_size != 2'b00) mem_q[a1] <= c_op2[15:8];
      if (c_word) begin
        mem_q[a2] <= c_op2[23:16];
        mem_q[a3] <= c_op2[31:24];
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.stall_out      = ~in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.pc_out         = pc_q;
  assign bus.ld_result_out  = ld_q;
  assign bus.alu_result_out = alu_q;
  assign bus.instr_out      = instr_q;
  assign bus.control_out    = ctrl_q;
  assign bus.misalign_out   = mis_q;

endmodule

// File: tb/tb_mem_stage_mw_pipe.sv
// Directed bench for mem_stage_mw_pipe (MEM_LATENCY=2) with hand-computed expectations.
module tb_mem_stage_mw_pipe;

  localparam logic [23:0] CTL_LD = 24'h002000;
  localparam logic [23:0] CTL_ST = 24'h004000;
  localparam logic [23:0] CTL_AL = 24'h000001;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mem_stage_mw_pipe_if #(.DATA_W(32), .CTRL_W(24)) bus ();

  mem_stage_mw_pipe #(
    .DATA_W(32), .ADDR_W(10), .CTRL_W(24), .MEM_LATENCY(2), .LD_BIT(13), .ST_BIT(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] op2,
                       input logic [23:0] ctrl, input logic [1:0] size, input logic sign);
    bus.pc_in         = pc;
    bus.alu_result_in = alu;
    bus.op2_in        = op2;
    bus.instr_in      = pc ^ 32'h13;
    bus.control_in    = ctrl;
    bus.size_in       = size;
    bus.sign_in       = sign;
    bus.in_valid      = 1'b1;
  endtask

  // Drives one op, lets it be accepted, then counts cycles until out_valid (bounded).
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] op2,
                       input logic [23:0] ctrl, input logic [1:0] size, input logic sign,
                       output int lat, output int stalls);
    drive(pc, alu, op2, ctrl, size, sign);
    #1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    stalls = 0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.stall_out) stalls++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.pc_out !== 32'h0 || bus.alu_result_out !== 32'h0) begin n_err++;
      $display("FAIL reset_pc_alu: got %h/%h want 0/0", bus.pc_out, bus.alu_result_out); end
    n_vec++; if (bus.ld_result_out !== 32'h0 || bus.instr_out !== 32'h0) begin n_err++;
      $display("FAIL reset_ld_instr: got %h/%h want 0/0", bus.ld_result_out, bus.instr_out); end
    n_vec++; if (bus.control_out !== 24'h0 || bus.misalign_out !== 1'b0) begin n_err++;
      $display("FAIL reset_ctrl_mis: got %h/%b want 0/0", bus.control_out, bus.misalign_out); end
    n_vec++; if (bus.stall_out !== 1'b0) begin n_err++;
      $display("FAIL reset_stall: got %b want 0", bus.stall_out); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_nonmem();
    int lat, st;
    issue(32'h100, 32'h0000_1234, 32'h0, CTL_AL, 2'b10, 1'b0, lat, st);
    n_vec++; if (lat != 1) begin n_err++;
      $display("FAIL nonmem_latency: got %0d want 1", lat); end
    n_vec++; if (bus.alu_result_out !== 32'h1234 || bus.ld_result_out !== 32'h0) begin n_err++;
      $display("FAIL nonmem_alu_ld: got %h/%h want 1234/0", bus.alu_result_out, bus.ld_result_out); end
    n_vec++; if (bus.pc_out !== 32'h100 || bus.instr_out !== 32'h113) begin n_err++;
      $display("FAIL nonmem_pc_instr: got %h/%h want 100/113", bus.pc_out, bus.instr_out); end
    n_vec++; if (bus.control_out !== CTL_AL || bus.misalign_out !== 1'b0) begin n_err++;
      $display("FAIL nonmem_ctrl_mis: got %h/%b want %h/0", bus.control_out, bus.misalign_out, CTL_AL); end
  endtask

  task automatic test_store_load_word();
    int lat, st;
    issue(32'h200, 32'h10, 32'hDEAD_BEEF, CTL_ST, 2'b10, 1'b0, lat, st);
    n_vec++; if (lat != 3 || st != 2) begin n_err++;
      $display("FAIL st_word_timing: got lat %0d stall %0d want 3/2", lat, st); end
    n_vec++; if (bus.ld_result_out !== 32'h0 || bus.misalign_out !== 1'b0) begin n_err++;
      $display("FAIL st_word_ld: got %h/%b want 0/0", bus.ld_result_out, bus.misalign_out); end
    issue(32'h204, 32'h10, 32'h0, CTL_LD, 2'b10, 1'b0, lat, st);
    n_vec++; if (lat != 3 || st != 2) begin n_err++;
      $display("FAIL ld_word_timing: got lat %0d stall %0d want 3/2", lat, st); end
    n_vec++; if (bus.ld_result_out !== 32'hDEAD_BEEF) begin n_err++;
      $display("FAIL ld_word_data: got %h want deadbeef", bus.ld_result_out); end
    // Known contents for the misalign and flush scenarios.
    issue(32'h208, 32'h14, 32'h5566_7788, CTL_ST, 2'b10, 1'b0, lat, st);
    issue(32'h20C, 32'h20, 32'hA5A5_A5A5, CTL_ST, 2'b10, 1'b0, lat, st);
    // LD+ST together is a store.
    issue(32'h210, 32'h24, 32'h0BAD_F00D, CTL_LD | CTL_ST, 2'b10, 1'b0, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'h0) begin n_err++;
      $display("FAIL ldst_both_ld: got %h want 0", bus.ld_result_out); end
    issue(32'h214, 32'h24, 32'h0, CTL_LD, 2'b10, 1'b0, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'h0BAD_F00D) begin n_err++;
      $display("FAIL ldst_both_written: got %h want 0badf00d", bus.ld_result_out); end
  endtask

  task automatic test_subword();
    int lat, st;
    issue(32'h300, 32'h13, 32'h0, CTL_LD, 2'b00, 1'b1, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'hFFFF_FFDE) begin n_err++;
      $display("FAIL ld_byte_sext: got %h want ffffffde", bus.ld_result_out); end
    issue(32'h304, 32'h13, 32'h0, CTL_LD, 2'b00, 1'b0, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'h0000_00DE) begin n_err++;
      $display("FAIL ld_byte_zext: got %h want 000000de", bus.ld_result_out); end
    issue(32'h308, 32'h12, 32'h0, CTL_LD, 2'b01, 1'b0, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'h0000_DEAD) begin n_err++;
      $display("FAIL ld_half_zext: got %h want 0000dead", bus.ld_result_out); end
    issue(32'h30C, 32'h12, 32'h0, CTL_LD, 2'b01, 1'b1, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'hFFFF_DEAD) begin n_err++;
      $display("FAIL ld_half_sext: got %h want ffffdead", bus.ld_result_out); end
    issue(32'h310, 32'h10, 32'h0, CTL_LD, 2'b00, 1'b1, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'hFFFF_FFEF) begin n_err++;
      $display("FAIL ld_byte0_sext: got %h want ffffffef", bus.ld_result_out); end
    // Half store writes only two bytes: 0x14..0x15 become 0x1234, 0x16..0x17 keep 0x5566.
    issue(32'h314, 32'h14, 32'hFFFF_1234, CTL_ST, 2'b01, 1'b0, lat, st);
    issue(32'h318, 32'h14, 32'h0, CTL_LD, 2'b11, 1'b0, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'h5566_1234) begin n_err++;
      $display("FAIL st_half_bytes: got %h want 55661234", bus.ld_result_out); end
    issue(32'h31C, 32'h14, 32'h7788, CTL_ST, 2'b01, 1'b0, lat, st);
  endtask

  task automatic test_misalign();
    int lat, st;
    issue(32'h400, 32'h12, 32'hCAFE_F00D, CTL_ST, 2'b10, 1'b0, lat, st);
    n_vec++; if (lat != 1 || bus.misalign_out !== 1'b1) begin n_err++;
      $display("FAIL mis_st_word: got lat %0d mis %b want 1/1", lat, bus.misalign_out); end
    n_vec++; if (bus.ld_result_out !== 32'h0 || bus.alu_result_out !== 32'h12) begin n_err++;
      $display("FAIL mis_st_fields: got %h/%h want 0/12", bus.ld_result_out, bus.alu_result_out); end
    issue(32'h404, 32'h11, 32'h0, CTL_LD, 2'b01, 1'b0, lat, st);
    n_vec++; if (lat != 1 || bus.misalign_out !== 1'b1 || bus.ld_result_out !== 32'h0) begin
      n_err++;
      $display("FAIL mis_ld_half: got lat %0d mis %b ld %h want 1/1/0", lat, bus.misalign_out,
               bus.ld_result_out); end
    issue(32'h408, 32'h12, 32'h0, CTL_LD, 2'b01, 1'b0, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'h0000_DEAD || bus.misalign_out !== 1'b0) begin n_err++;
      $display("FAIL mis_no_write_lo: got %h/%b want 0000dead/0", bus.ld_result_out,
               bus.misalign_out); end
    issue(32'h40C, 32'h14, 32'h0, CTL_LD, 2'b10, 1'b0, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'h5566_7788) begin n_err++;
      $display("FAIL mis_no_write_hi: got %h want 55667788", bus.ld_result_out); end
  endtask

  task automatic test_flush();
    int lat, st, seen;
    drive(32'h500, 32'h20, 32'h1122_3344, CTL_ST, 2'b10, 1'b0);
    #1;
    step();
    bus.in_valid = 1'b0;
    step();
    // Counter is now 0: without flush the store would commit on the next edge.
    bus.flush = 1'b1;
    drive(32'h504, 32'h777, 32'h0, CTL_AL, 2'b10, 1'b0);
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++;
      $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      step();
    end
    n_vec++; if (seen != 0) begin n_err++;
      $display("FAIL flush_out_valid: got %0d valid cycles want 0", seen); end
    issue(32'h508, 32'h20, 32'h0, CTL_LD, 2'b10, 1'b0, lat, st);
    n_vec++; if (bus.ld_result_out !== 32'hA5A5_A5A5) begin n_err++;
      $display("FAIL flush_store_dropped: got %h want a5a5a5a5", bus.ld_result_out); end
  endtask

  task automatic test_hold_back_to_back();
    int bad;
    step();
    bus.out_ready = 1'b0;
    drive(32'h600, 32'hABC, 32'h0, CTL_AL, 2'b10, 1'b0);
    #1;
    step();
    drive(32'h604, 32'hDEF, 32'h0, CTL_AL, 2'b10, 1'b0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.out_valid !== 1'b1 || bus.alu_result_out !== 32'hABC || bus.pc_out !== 32'h600 ||
          bus.in_ready !== 1'b0 || bus.stall_out !== 1'b1) bad++;
      step();
    end
    n_vec++; if (bad != 0) begin n_err++;
      $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    n_vec++; if (bus.alu_result_out !== 32'hABC) begin n_err++;
      $display("FAIL hold_no_accept: got %h want abc", bus.alu_result_out); end
    bus.out_ready = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++;
      $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1 || bus.alu_result_out !== 32'hDEF) begin n_err++;
      $display("FAIL b2b_load: got %b/%h want 1/def", bus.out_valid, bus.alu_result_out); end
    step();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++;
      $display("FAIL b2b_drop: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_wait();
    drive(32'h700, 32'h30, 32'h1234_5678, CTL_ST, 2'b10, 1'b0);
    #1;
    step();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.stall_out !== 1'b1) begin n_err++;
      $display("FAIL rst_wait_entered: got stall %b want 1", bus.stall_out); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.stall_out !== 1'b0) begin n_err++;
      $display("FAIL rst_mid_valid_stall: got %b/%b want 0/0", bus.out_valid, bus.stall_out); end
    n_vec++; if (bus.pc_out !== 32'h0 || bus.alu_result_out !== 32'h0 ||
                 bus.instr_out !== 32'h0 || bus.control_out !== 24'h0) begin n_err++;
      $display("FAIL rst_mid_fields: got %h/%h/%h/%h want 0", bus.pc_out, bus.alu_result_out,
               bus.instr_out, bus.control_out); end
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.pc_in = '0;
    bus.alu_result_in = '0;
    bus.op2_in = '0;
    bus.instr_in = '0;
    bus.control_in = '0;
    bus.size_in = 2'b10;
    bus.sign_in = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_nonmem();
    test_store_load_word();
    test_subword();
    test_misalign();
    test_flush();
    test_hold_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
